// File: rtl/pe_ctrl_pkg.sv
// Shared types and PE timing constants for the PE controller.
// The PE contract is fixed: one cycle of register-file read latency and one cycle from dout to psum.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam int unsigned REGFILE_RD_LAT = 1;
  localparam int unsigned MAC_DOUT_LAT   = 1;

endpackage

// File: rtl/pe_ctrl_cnt.sv
// Loadable wrap counter: counts 0..last_val on inc, then wraps to 0.
// Shared by the weight index, filter tap index, window count and output count.
module pe_ctrl_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] last_val,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: assigning cnt_d before any branch keeps this purely combinational (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = (cnt_q == last_val) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pe_ctrl.sv
// Sequencer for one PE: loads K weights, streams activations in K-tap windows,
// inserts a dout per window and collects N partial sums.
module pe_ctrl #(
  parameter int unsigned DATA_BITWIDTH     = 8,
  parameter int unsigned ROM_ADDR_BITWIDTH = 4,
  parameter int unsigned CNT_BITWIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ROM_ADDR_BITWIDTH:0]   cfg_k,
  input  logic [CNT_BITWIDTH-1:0]      cfg_num_out,
  input  logic                         wght_valid,
  input  logic [DATA_BITWIDTH-1:0]     wght_data,
  output logic                         wght_ready,
  input  logic                         iact_valid,
  input  logic [DATA_BITWIDTH-1:0]     iact_data,
  output logic                         iact_ready,
  output logic                         en_regfile_wght,
  output logic                         we_regfile_wght,
  output logic                         en_MAC_din,
  output logic                         en_MAC_dout,
  output logic [DATA_BITWIDTH-1:0]     wght_regfile_in,
  output logic [DATA_BITWIDTH-1:0]     iact,
  output logic [ROM_ADDR_BITWIDTH-1:0] rd_addr_regfile,
  output logic [ROM_ADDR_BITWIDTH-1:0] wr_addr_regfile,
  input  logic [31:0]                  psum_in,
  output logic [31:0]                  psum_out,
  output logic                         psum_valid,
  output logic                         busy,
  output logic                         done
);

  import pe_ctrl_pkg::*;

  localparam int unsigned AW = ROM_ADDR_BITWIDTH;
  localparam int unsigned KW = ROM_ADDR_BITWIDTH + 1;
  localparam logic [KW-1:0] K_MAX = KW'(1) << AW;

  // Window-end marker travels through these taps: last din, dout, psum capture.
  localparam int unsigned LAST_DIN_TAP = REGFILE_RD_LAT - 1;
  localparam int unsigned DOUT_TAP     = REGFILE_RD_LAT;
  localparam int unsigned CAP_TAP      = REGFILE_RD_LAT + MAC_DOUT_LAT;
  localparam int unsigned WEND_LEN     = CAP_TAP + 1;

  state_e                   state_q, state_d;
  logic [KW-1:0]            cfg_k_q, cfg_k_d;
  logic [CNT_BITWIDTH-1:0]  cfg_n_q, cfg_n_d;
  logic [DATA_BITWIDTH-1:0] iact_q, iact_d;
  logic                     din_q, din_d;
  logic [WEND_LEN-1:0]      wend_q, wend_d;
  logic [31:0]              psum_hold_q, psum_hold_d;

  logic                     cnt_load, w_inc, k_inc, win_inc, out_inc;
  logic [AW-1:0]            w_idx, k_idx, k_last_val;
  logic [CNT_BITWIDTH-1:0]  win_cnt, out_cnt, n_last_val;
  logic                     cfg_ok, k_last, win_last, out_last, cap;

  // K = 2^AW truncates to 0 here, and 0 - 1 wraps to the correct all-ones last index.
  assign k_last_val = cfg_k_q[AW-1:0] - AW'(1);
  assign n_last_val = cfg_n_q - CNT_BITWIDTH'(1);
  assign k_last     = (k_idx == k_last_val);
  assign win_last   = (win_cnt == n_last_val);
  assign out_last   = (out_cnt == n_last_val);
  assign cap        = wend_q[CAP_TAP];
  assign out_inc    = cap;
  assign cfg_ok     = (cfg_k != '0) && (cfg_k <= K_MAX) && (cfg_num_out != '0);

  pe_ctrl_cnt #(.WIDTH(AW)) u_w_idx (
    .clk(clk), .rst(rst), .load(cnt_load), .load_val('0),
    .inc(w_inc), .last_val(k_last_val), .cnt(w_idx)
  );

  pe_ctrl_cnt #(.WIDTH(AW)) u_k_idx (
    .clk(clk), .rst(rst), .load(cnt_load), .load_val('0),
    .inc(k_inc), .last_val(k_last_val), .cnt(k_idx)
  );

  pe_ctrl_cnt #(.WIDTH(CNT_BITWIDTH)) u_win_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .load_val('0),
    .inc(win_inc), .last_val(n_last_val), .cnt(win_cnt)
  );

  pe_ctrl_cnt #(.WIDTH(CNT_BITWIDTH)) u_out_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .load_val('0),
    .inc(out_inc), .last_val(n_last_val), .cnt(out_cnt)
  );

  always_comb begin
    state_d         = state_q;
    cfg_k_d         = cfg_k_q;
    cfg_n_d         = cfg_n_q;
    iact_d          = iact_q;
    din_d           = 1'b0;
    wend_d          = {wend_q[WEND_LEN-2:0], 1'b0};
    psum_hold_d     = cap ? psum_in : psum_hold_q;
    cnt_load        = 1'b0;
    w_inc           = 1'b0;
    k_inc           = 1'b0;
    win_inc         = 1'b0;
    wght_ready      = 1'b0;
    iact_ready      = 1'b0;
    en_regfile_wght = 1'b0;
    we_regfile_wght = 1'b0;
    wght_regfile_in = '0;
    rd_addr_regfile = '0;
    wr_addr_regfile = '0;
    done            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) begin
          cfg_k_d  = cfg_k;
          cfg_n_d  = cfg_num_out;
          cnt_load = 1'b1;
          state_d  = S_LOAD_W;
        end
      end

      S_LOAD_W: begin
        wght_ready = 1'b1;
        if (wght_valid) begin
          en_regfile_wght = 1'b1;
          we_regfile_wght = 1'b1;
          wr_addr_regfile = w_idx;
          wght_regfile_in = wght_data;
          w_inc           = 1'b1;
          if (w_idx == k_last_val) begin
            state_d = S_COMPUTE;
          end
        end
      end

      S_COMPUTE: begin
        // Hold off the next window until its first din can no longer meet the dout.
        iact_ready = !(wend_q[LAST_DIN_TAP] || wend_q[DOUT_TAP]);
        if (iact_valid && iact_ready) begin
          en_regfile_wght = 1'b1;
          rd_addr_regfile = k_idx;
          iact_d          = iact_data;
          din_d           = 1'b1;
          k_inc           = 1'b1;
          if (k_last) begin
            wend_d[0] = 1'b1;
            win_inc   = 1'b1;
            if (win_last) begin
              state_d = S_DRAIN;
            end
          end
        end
      end

      S_DRAIN: begin
        if (cap && out_last) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_k_q     <= '0;
      cfg_n_q     <= '0;
      iact_q      <= '0;
      din_q       <= 1'b0;
      wend_q      <= '0;
      psum_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_k_q     <= cfg_k_d;
      cfg_n_q     <= cfg_n_d;
      iact_q      <= iact_d;
      din_q       <= din_d;
      wend_q      <= wend_d;
      psum_hold_q <= psum_hold_d;
    end
  end

  assign iact        = iact_q;
  assign en_MAC_din  = din_q;
  assign en_MAC_dout = wend_q[DOUT_TAP];
  assign psum_valid  = cap;
  assign psum_out    = cap ? psum_in : psum_hold_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_ctrl.sv
// Bench for pe_ctrl with a behavioural PE attached; expected psums are plain
// dot products of each activation window with the loaded weights.
module tb_pe_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   cfg_k;
  logic [CW-1:0] cfg_num_out;
  logic          wght_valid, wght_ready, iact_valid, iact_ready;
  logic [DW-1:0] wght_data, iact_data, wght_regfile_in, iact;
  logic          en_regfile_wght, we_regfile_wght, en_MAC_din, en_MAC_dout;
  logic [AW-1:0] rd_addr_regfile, wr_addr_regfile;
  logic [31:0]   psum_in, psum_out;
  logic          psum_valid, busy, done;

  pe_ctrl #(.DATA_BITWIDTH(DW), .ROM_ADDR_BITWIDTH(AW), .CNT_BITWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_num_out(cfg_num_out),
    .wght_valid(wght_valid), .wght_data(wght_data), .wght_ready(wght_ready),
    .iact_valid(iact_valid), .iact_data(iact_data), .iact_ready(iact_ready),
    .en_regfile_wght(en_regfile_wght), .we_regfile_wght(we_regfile_wght),
    .en_MAC_din(en_MAC_din), .en_MAC_dout(en_MAC_dout),
    .wght_regfile_in(wght_regfile_in), .iact(iact),
    .rd_addr_regfile(rd_addr_regfile), .wr_addr_regfile(wr_addr_regfile),
    .psum_in(psum_in), .psum_out(psum_out), .psum_valid(psum_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural PE: register file, MAC accumulator and psum register.
  logic [DW-1:0] rf [2**AW];
  logic [DW-1:0] rf_rd = '0;
  logic [31:0]   acc = '0;
  logic [31:0]   psum_reg = '0;
  assign psum_in = psum_reg;

  always @(posedge clk) begin
    if (en_regfile_wght && we_regfile_wght) rf[wr_addr_regfile] <= wght_regfile_in;
    if (en_regfile_wght && !we_regfile_wght) rf_rd <= rf[rd_addr_regfile];
    if (en_MAC_din) acc <= acc + 32'(iact) * 32'(rf_rd);
    if (en_MAC_dout) begin
      psum_reg <= acc;
      acc      <= '0;
    end
    if (rst) acc <= '0;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation logs, filled away from the active edge.
  int   wr_addr_log[$], wr_data_log[$], wr_cyc_log[$];
  logic [31:0] psum_got[$];
  int   din_n, acc_n, viol, din_misalign, pv_cyc, done_n, done_cyc, busy_n, hs_n;
  int   min_gap, last_acc_cyc;
  bit   prev_acc = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (en_regfile_wght && we_regfile_wght) begin
        wr_addr_log.push_back(int'(wr_addr_regfile));
        wr_data_log.push_back(int'(wght_regfile_in));
        wr_cyc_log.push_back(cyc);
      end
      if (en_MAC_din) din_n++;
      if (en_MAC_din != prev_acc) din_misalign++;
      prev_acc = iact_valid && iact_ready;
      if (iact_valid && iact_ready) begin
        acc_n++;
        if (last_acc_cyc >= 0 && cyc - last_acc_cyc < min_gap) min_gap = cyc - last_acc_cyc;
        last_acc_cyc = cyc;
      end
      if (en_MAC_dout && (iact_ready || en_MAC_din)) viol++;
      if (psum_valid) begin
        psum_got.push_back(psum_out);
        pv_cyc = cyc;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (busy) busy_n++;
      if (wght_ready || iact_ready || en_regfile_wght || en_MAC_din || en_MAC_dout) hs_n++;
    end else begin
      prev_acc = 1'b0;
    end
  end

  int wts[16];
  int acts[1024];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete(); psum_got.delete();
    din_n = 0; acc_n = 0; viol = 0; din_misalign = 0; pv_cyc = -100; done_n = 0;
    done_cyc = -1; busy_n = 0; hs_n = 0; min_gap = 1000; last_acc_cyc = -1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {wght_ready, iact_ready, en_regfile_wght, we_regfile_wght, en_MAC_din,
                           en_MAC_dout, psum_valid, busy, done}, '0);
    check({tag, "_data"}, {wght_regfile_in, iact, rd_addr_regfile, wr_addr_regfile, psum_out}, '0);
  endtask

  task automatic do_start(input int k, input int n);
    start = 1'b1;
    cfg_k = (AW+1)'(k);
    cfg_num_out = CW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic load_weights(input string tag, input int k, input bit gaps);
    int idx = 0;
    int b = 0;
    while (idx < k && b < 500) begin
      wght_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wght_data  = DW'(wts[idx]);
      @(negedge clk);
      if (wght_valid && wght_ready) idx++;
      b++;
      tick();
    end
    wght_valid = 1'b0;
    check({tag, "_wcount"}, idx, k);
  endtask

  task automatic feed_iacts(input string tag, input int total, input int mode, input bit busy_start);
    int i = 0;
    int b = 0;
    while (i < total && b < 5000) begin
      case (mode)
        0:       iact_valid = 1'b1;
        1:       iact_valid = (b % 2 == 0);
        default: iact_valid = ($urandom_range(0, 3) != 0);
      endcase
      iact_data = DW'(acts[i]);
      if (busy_start && b == 2) begin
        start = 1'b1; cfg_k = (AW+1)'(1); cfg_num_out = CW'(7);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy_start && b == 2) check({tag, "_busy_at_start"}, busy, 1'b1);
      if (iact_valid && iact_ready) i++;
      b++;
      tick();
    end
    iact_valid = 1'b0;
    start = 1'b0;
    check({tag, "_icount"}, i, total);
  endtask

  task automatic run_job(input string tag, input int k, input int n, input int mode,
                         input bit wgap, input bit busy_start);
    int got = 0;
    int b = 0;
    longint s;
    clear_logs();
    do_start(k, n);
    load_weights(tag, k, wgap);
    @(negedge clk);
    check({tag, "_in_compute"}, {wght_ready, iact_ready, busy}, 3'b011);
    tick();
    feed_iacts(tag, k * n, mode, busy_start);
    while (got == 0 && b < 3000) begin
      @(negedge clk);
      if (done) got = 1;
      b++;
    end
    tick();
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_idle_after"}, busy, 1'b0);
    check({tag, "_wr_n"}, wr_addr_log.size(), k);
    for (int j = 0; j < k && j < wr_addr_log.size(); j++) begin
      check($sformatf("%s_wr%0d", tag, j), {wr_addr_log[j], wr_data_log[j]}, {j, wts[j]});
    end
    check({tag, "_npsum"}, psum_got.size(), n);
    for (int w = 0; w < n && w < psum_got.size(); w++) begin
      s = 0;
      for (int j = 0; j < k; j++) s += longint'(acts[w*k + j]) * longint'(wts[j]);
      check($sformatf("%s_psum%0d", tag, w), psum_got[w], s[31:0]);
    end
    check({tag, "_din_eq_acc"}, din_n, acc_n);
    check({tag, "_din_align"}, din_misalign, 0);
    check({tag, "_dout_no_overlap"}, viol, 0);
    check({tag, "_done_after_pv"}, done_cyc, pv_cyc + 1);
    check({tag, "_done_once"}, done_n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b1; cfg_k = '0; cfg_num_out = '0;
    wght_valid = 1'b1; wght_data = 8'hA5; iact_valid = 1'b1; iact_data = 8'h5A;
    clear_logs();
    repeat (2) tick();
    @(negedge clk);
    check_all_zero("reset");
    start = 1'b0; wght_valid = 1'b0; iact_valid = 1'b0; wght_data = '0; iact_data = '0;
    tick();
    rst = 1'b0;
    tick();

    // Weights 1,2,3; activations 1..6 give 14 then 32.
    wts[0] = 1; wts[1] = 2; wts[2] = 3;
    for (int i = 0; i < 6; i++) acts[i] = i + 1;
    run_job("k3n2", 3, 2, 0, 1'b0, 1'b0);
    check("k3n2_w_consec", (wr_cyc_log.size() == 3) ? wr_cyc_log[2] - wr_cyc_log[0] : -1, 2);
    check("k3n2_psum_vals", (psum_got.size() == 2) ? {psum_got[0], psum_got[1]} : '0, {32'd14, 32'd32});

    // K=1: every accept is its own window.
    wts[0] = 5;
    for (int i = 0; i < 4; i++) acts[i] = i + 1;
    run_job("k1n4", 1, 4, 0, 1'b0, 1'b0);
    check("k1n4_gap_ge2", min_gap >= 2, 1'b1);

    // K=4 with iact_valid toggling every cycle.
    for (int j = 0; j < 4; j++) wts[j] = $urandom_range(0, 255);
    for (int i = 0; i < 4; i++) acts[i] = $urandom_range(0, 255);
    run_job("k4n1_tog", 4, 1, 1, 1'b0, 1'b0);

    // Rejected starts: bad K, oversize K, zero N.
    clear_logs();
    wght_valid = 1'b1; iact_valid = 1'b1;
    do_start(0, 2);  repeat (2) tick();
    do_start(17, 2); repeat (2) tick();
    do_start(3, 0);  repeat (2) tick();
    check("cfg_reject_busy", busy_n, 0);
    check("cfg_reject_hs", hs_n, 0);
    wght_valid = 1'b0; iact_valid = 1'b0;
    tick();

    // start while busy must not disturb the running job.
    for (int j = 0; j < 3; j++) wts[j] = $urandom_range(0, 255);
    for (int i = 0; i < 9; i++) acts[i] = $urandom_range(0, 255);
    run_job("busy_start", 3, 3, 2, 1'b1, 1'b1);

    // Reset mid-window, then a fresh job.
    clear_logs();
    for (int j = 0; j < 4; j++) wts[j] = $urandom_range(1, 255);
    do_start(4, 2);
    load_weights("abort", 4, 1'b0);
    tick();
    feed_iacts("abort", 2, 0, 1'b0);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int j = 0; j < 2; j++) wts[j] = $urandom_range(0, 255);
    for (int i = 0; i < 4; i++) acts[i] = $urandom_range(0, 255);
    run_job("after_abort", 2, 2, 2, 1'b1, 1'b0);

    // Boundaries: maximum K, maximum N.
    for (int j = 0; j < 16; j++) wts[j] = $urandom_range(0, 255);
    for (int i = 0; i < 32; i++) acts[i] = $urandom_range(0, 255);
    run_job("kmax", 16, 2, 2, 1'b1, 1'b0);
    wts[0] = $urandom_range(1, 255);
    for (int i = 0; i < 63; i++) acts[i] = $urandom_range(0, 255);
    run_job("nmax", 1, 63, 0, 1'b0, 1'b0);

    // Randomized jobs.
    for (int r = 0; r < 4; r++) begin
      int k, n;
      k = $urandom_range(1, 16);
      n = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) wts[j] = $urandom_range(0, 255);
      for (int i = 0; i < k * n; i++) acts[i] = $urandom_range(0, 255);
      run_job($sformatf("rand%0d", r), k, n, int'($urandom_range(0, 2)), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
